hpdcache_fence_seq: RTL

- Fence sequencer between the CVA6 commit stage and the write-back HPDcache subsystem.
- On a committed FENCE or FENCE.I it:
  - stalls new memory issue;
  - drains the store buffer;
  - issues a write-back flush to the HPDcache, and optionally an invalidate;
  - for FENCE.I, pulses the I-cache flush;
  - returns a single completion pulse to commit.
- Implements the DcacheFlushOnFence and DcacheInvalidateOnFlush configuration semantics.

---
 rtl/hpdcache_fence_seq_pkg.sv | 21 ++
 rtl/hpdcache_req_timeout.sv | 28 ++
 rtl/hpdcache_fence_seq.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/hpdcache_fence_seq_pkg.sv
// Shared types for the HPDcache fence sequencer and anything that observes it.
package hpdcache_fence_seq_pkg;

  typedef enum logic [2:0] {
    FS_IDLE       = 3'd0,
    FS_DRAIN      = 3'd1,
    FS_FLUSH_REQ  = 3'd2,
    FS_FLUSH_WAIT = 3'd3,
    FS_INVAL_REQ  = 3'd4,
    FS_INVAL_WAIT = 3'd5,
    FS_ICACHE     = 3'd6,
    FS_DONE       = 3'd7
  } fence_seq_state_e;

  // Width of a counter that must reach 'cycles'; at least one bit so a
  // disabled timeout still yields a legal vector.
  function automatic int unsigned fence_to_width(input int unsigned cycles);
    return (cycles == 0) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/hpdcache_req_timeout.sv
// Clearable saturating cycle counter that flags when it sits at LIMIT.
module hpdcache_req_timeout #(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned LIMIT = 4095
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  logic [WIDTH-1:0] cnt_q;

  // Count enabled cycles, restart on clear, hold at all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign hit_o = (cnt_q == WIDTH'(LIMIT));

endmodule

// File: rtl/hpdcache_fence_seq.sv
// Fence sequencer: drains stores, flushes/invalidates the D-cache and
// optionally flushes the I-cache before signalling fence completion.
module hpdcache_fence_seq
  import hpdcache_fence_seq_pkg::*;
#(
  parameter bit          FlushOnFence      = 1'b1,
  parameter bit          InvalidateOnFlush = 1'b0,
  parameter int unsigned TimeoutCycles     = 4096,
  parameter int unsigned PerfCntWidth      = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    fence_valid_i,
  input  logic                    fence_is_i_i,
  output logic                    fence_ready_o,
  output logic                    fence_done_o,
  output logic                    fence_err_o,
  output logic                    stall_issue_o,
  input  logic                    sb_empty_i,
  output logic                    flush_valid_o,
  input  logic                    flush_ready_i,
  input  logic                    flush_done_i,
  output logic                    inval_valid_o,
  input  logic                    inval_ready_i,
  input  logic                    inval_done_i,
  output logic                    icache_flush_o,
  output logic [PerfCntWidth-1:0] busy_cycles_o
);

  localparam int unsigned ToWidth = fence_to_width(TimeoutCycles);
  localparam int unsigned ToLimit = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;

  fence_seq_state_e        state_q, state_d;
  fence_seq_state_e        after_drain, after_flush, after_inval;
  logic                    kind_i_q;
  logic                    err_q, err_d;
  logic                    timeout;
  logic [PerfCntWidth-1:0] busy_q;

  // Successor states once each phase completes, resolved from configuration and fence kind.
  always_comb begin
    after_inval = kind_i_q ? FS_ICACHE : FS_DONE;
    if (InvalidateOnFlush) begin
      after_flush = FS_INVAL_REQ;
    end else begin
      after_flush = after_inval;
    end
    if (FlushOnFence || kind_i_q) begin
      after_drain = FS_FLUSH_REQ;
    end else begin
      after_drain = after_inval;
    end
  end

  // Next-state logic; a timeout in any wait state forces DONE with the error flag.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      FS_IDLE: begin
        if (fence_valid_i) begin
          state_d = FS_DRAIN;
          err_d   = 1'b0;
        end
      end
      FS_DRAIN: begin
        if (sb_empty_i) begin
          state_d = after_drain;
        end else if (timeout) begin
          state_d = FS_DONE;
          err_d   = 1'b1;
        end
      end
      FS_FLUSH_REQ: begin
        if (flush_ready_i) begin
          state_d = flush_done_i ? after_flush : FS_FLUSH_WAIT;
        end else if (timeout) begin
          state_d = FS_DONE;
          err_d   = 1'b1;
        end
      end
      FS_FLUSH_WAIT: begin
        if (flush_done_i) begin
          state_d = after_flush;
        end else if (timeout) begin
          state_d = FS_DONE;
          err_d   = 1'b1;
        end
      end
      FS_INVAL_REQ: begin
        if (inval_ready_i) begin
          state_d = inval_done_i ? after_inval : FS_INVAL_WAIT;
        end else if (timeout) begin
          state_d = FS_DONE;
          err_d   = 1'b1;
        end
      end
      FS_INVAL_WAIT: begin
        if (inval_done_i) begin
          state_d = after_inval;
        end else if (timeout) begin
          state_d = FS_DONE;
          err_d   = 1'b1;
        end
      end
      FS_ICACHE: state_d = FS_DONE;
      FS_DONE:   state_d = FS_IDLE;
      default:   state_d = FS_IDLE;
    endcase
  end

  // State, error flag and fence kind registers; kind is captured only at acceptance.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= FS_IDLE;
      err_q    <= 1'b0;
      kind_i_q <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if ((state_q == FS_IDLE) && fence_valid_i) begin
        kind_i_q <= fence_is_i_i;
      end
    end
  end

  if (TimeoutCycles > 0) begin : g_timeout
    logic to_en, to_clr;
    assign to_en  = (state_q inside {FS_DRAIN, FS_FLUSH_REQ, FS_FLUSH_WAIT,
                                     FS_INVAL_REQ, FS_INVAL_WAIT});
    assign to_clr = (state_d != state_q);

    hpdcache_req_timeout #(
      .WIDTH (ToWidth),
      .LIMIT (ToLimit)
    ) u_timeout (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (to_clr),
      .en_i  (to_en),
      .hit_o (timeout)
    );
  end else begin : g_no_timeout
    assign timeout = 1'b0;
  end

  // Saturating count of every cycle spent outside IDLE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else if ((state_q != FS_IDLE) && (busy_q != '1)) begin
      busy_q <= busy_q + 1'b1;
    end
  end

  assign fence_ready_o  = (state_q == FS_IDLE);
  assign stall_issue_o  = (state_q != FS_IDLE);
  assign flush_valid_o  = (state_q == FS_FLUSH_REQ);
  assign inval_valid_o  = (state_q == FS_INVAL_REQ);
  assign icache_flush_o = (state_q == FS_ICACHE);
  assign fence_done_o   = (state_q == FS_DONE);
  assign fence_err_o    = (state_q == FS_DONE) && err_q;
  assign busy_cycles_o  = busy_q;

endmodule
